pwm_av_seq: RTL and testbench

Sequencer that replays a duty-cycle table from the on-chip `pwm_av_RAM` into a single PWM output. It sits directly downstream of the RAM, driving the RAM's s2 port as a read-only Avalon-MM master. It prefetches one table entry ahead so that duty changes land exactly on PWM period boundaries. A small Avalon-MM slave provides start address, length, period, control and status.

---
 rtl/pwm_av_seq_pkg.sv | 41 ++++
 rtl/pwm_av_seq_gen.sv | 70 +++++++
 rtl/pwm_av_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_pwm_av_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_av_seq_pkg.sv
// Shared constants, register map, table-entry field helpers and fetch-FSM states for pwm_av_seq.
package pwm_av_seq_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_START  = 2'd1;
    localparam logic [1:0] REG_LENGTH = 2'd2;
    localparam logic [1:0] REG_PERIOD = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_LOOP_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_DONE_BIT     = 1;
    localparam int STAT_UNDERRUN_BIT = 2;
    localparam int STAT_INDEX_LSB    = 16;

    localparam int ENTRY_DUTY_LSB = 0;
    localparam int ENTRY_DUTY_MSB = 15;
    localparam int ENTRY_REP_LSB  = 16;
    localparam int ENTRY_REP_MSB  = 31;

    localparam int MIN_PERIOD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    function automatic logic [15:0] entry_duty(input logic [31:0] entry);
        return entry[ENTRY_DUTY_MSB:ENTRY_DUTY_LSB];
    endfunction

    function automatic logic [15:0] entry_rep(input logic [31:0] entry);
        return entry[ENTRY_REP_MSB:ENTRY_REP_LSB];
    endfunction

endpackage

// File: rtl/pwm_av_seq_gen.sv
// PWM generator: period counter, duty compare, repeat down-counter, consume strobe and underrun detect.
module pwm_av_gen
    import pwm_av_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             drain,
    input  logic [CNT_W-1:0] period,
    input  logic             shadow_valid,
    input  logic [CNT_W-1:0] shadow_duty,
    input  logic [CNT_W-1:0] shadow_rep,
    output logic             consume,
    output logic             finish,
    output logic             underrun_set,
    output logic             pwm_out
);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] rep_load;
    logic             wrap;
    logic             period_end;

    assign last_cnt   = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD - 1)
                                                      : period - CNT_W'(1);
    assign rep_load   = (shadow_rep == '0) ? CNT_W'(1) : shadow_rep;
    assign wrap       = running && (cnt == last_cnt);
    assign period_end = wrap && (rem == CNT_W'(1));

    // A starved generator repeats the current duty rather than stopping, unless it is draining.
    assign consume      = !kill && shadow_valid && (!running || period_end);
    assign finish       = !kill && period_end && !shadow_valid && drain;
    assign underrun_set = !kill && period_end && !shadow_valid && !drain;

    always_ff @(posedge clk) begin
        if (reset || kill) begin
            running <= 1'b0;
            cnt     <= '0;
            duty    <= '0;
            rem     <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= running && (cnt < duty);
            if (consume) begin
                running <= 1'b1;
                cnt     <= '0;
                duty    <= shadow_duty;
                rem     <= rep_load;
            end else if (finish) begin
                running <= 1'b0;
                cnt     <= '0;
                pwm_out <= 1'b0;
            end else if (wrap) begin
                cnt <= '0;
                if (!period_end) begin
                    rem <= rem - CNT_W'(1);
                end
            end else if (running) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_av_seq.sv
// Duty-table sequencer: Avalon-MM control slave, read-only RAM master with one-entry prefetch, PWM out.
// Optional completion interrupt enabled by defining PWM_AV_SEQ_IRQ_EN.
//
// state     | meaning
// S_IDLE    | stopped, waiting for an enable rising edge with LENGTH != 0
// S_FETCH   | chipselect asserted at START+index for one cycle
// S_CAPTURE | RAM data valid, loaded into the shadow register
// S_HOLD    | shadow full, waiting for the generator to consume it
// S_DRAIN   | last entry playing, finish when its repeats run out
module pwm_av_seq
    import pwm_av_seq_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ctrl_address,
    input  logic              ctrl_write,
    input  logic [31:0]       ctrl_writedata,
    input  logic              ctrl_read,
    output logic [31:0]       ctrl_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    input  logic [31:0]       m_readdata,
    output logic              pwm_out
`ifdef PWM_AV_SEQ_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int LEN_W = ADDR_W + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] index_next;

    logic              ctrl_en;
    logic              ctrl_loop;
    logic              ctrl_irq_en;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic [CNT_W-1:0]  period;
    logic              done;
    logic              underrun;

    logic              shadow_valid;
    logic [CNT_W-1:0]  shadow_duty;
    logic [CNT_W-1:0]  shadow_rep;

    logic              busy;
    logic              wr_ctrl;
    logic              start_req;
    logic              abort;
    logic              last_entry;
    logic              consume;
    logic              finish;
    logic              underrun_set;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign busy       = (state != S_IDLE);
    assign wr_ctrl    = ctrl_write && (ctrl_address == REG_CTRL);
    assign start_req  = wr_ctrl && ctrl_writedata[CTRL_EN_BIT] && !ctrl_en
                        && (length != '0) && !busy;
    assign abort      = wr_ctrl && !ctrl_writedata[CTRL_EN_BIT] && busy;
    assign last_entry = ({1'b0, index} == (length - LEN_W'(1)));
    assign unused_bits = ^ctrl_writedata;

`ifdef PWM_AV_SEQ_IRQ_EN
    assign irq = done && ctrl_irq_en;
`endif

    always_comb begin
        state_next   = state;
        index_next   = index;
        m_chipselect = 1'b0;
        m_address    = '0;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    state_next = S_FETCH;
                    index_next = '0;
                end
            end
            S_FETCH: begin
                m_chipselect = 1'b1;
                m_address    = start_addr + index;
                state_next   = S_CAPTURE;
            end
            S_CAPTURE: state_next = S_HOLD;
            S_HOLD: begin
                if (consume) begin
                    if (!last_entry) begin
                        index_next = index + ADDR_W'(1);
                        state_next = S_FETCH;
                    end else if (ctrl_loop) begin
                        index_next = '0;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (finish) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (ctrl_address)
            REG_CTRL: begin
                rd_mux[STAT_BUSY_BIT]                  = busy;
                rd_mux[STAT_DONE_BIT]                  = done;
                rd_mux[STAT_UNDERRUN_BIT]              = underrun;
                rd_mux[STAT_INDEX_LSB +: ADDR_W]       = index;
            end
            REG_START:  rd_mux = 32'(start_addr);
            REG_LENGTH: rd_mux = 32'(length);
            REG_PERIOD: rd_mux = 32'(period);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            index         <= '0;
            ctrl_en       <= 1'b0;
            ctrl_loop     <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            start_addr    <= '0;
            length        <= '0;
            period        <= '0;
            done          <= 1'b0;
            underrun      <= 1'b0;
            shadow_valid  <= 1'b0;
            shadow_duty   <= '0;
            shadow_rep    <= '0;
            ctrl_readdata <= '0;
        end else begin
            state <= state_next;
            index <= index_next;

            if (wr_ctrl) begin
                ctrl_en   <= ctrl_writedata[CTRL_EN_BIT];
                ctrl_loop <= ctrl_writedata[CTRL_LOOP_BIT];
`ifdef PWM_AV_SEQ_IRQ_EN
                ctrl_irq_en <= ctrl_writedata[CTRL_IRQ_EN_BIT];
`endif
            end

            // Table geometry is frozen while a run is in progress.
            if (ctrl_write && !busy) begin
                case (ctrl_address)
                    REG_START:  start_addr <= ctrl_writedata[ADDR_W-1:0];
                    REG_LENGTH: length     <= ctrl_writedata[LEN_W-1:0];
                    REG_PERIOD: period     <= ctrl_writedata[CNT_W-1:0];
                    default: ;
                endcase
            end

            if (abort) begin
                shadow_valid <= 1'b0;
            end else if (state == S_CAPTURE) begin
                shadow_valid <= 1'b1;
                shadow_duty  <= CNT_W'(entry_duty(m_readdata));
                shadow_rep   <= CNT_W'(entry_rep(m_readdata));
            end else if (consume) begin
                shadow_valid <= 1'b0;
            end

            if (wr_ctrl && ctrl_writedata[STAT_DONE_BIT]) begin
                done <= 1'b0;
            end
            if (finish) begin
                done <= 1'b1;
            end
            if (start_req) begin
                done <= 1'b0;
            end

            if (wr_ctrl && ctrl_writedata[STAT_UNDERRUN_BIT]) begin
                underrun <= 1'b0;
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end

            if (ctrl_read) begin
                ctrl_readdata <= rd_mux;
            end
        end
    end

    pwm_av_gen #(
        .CNT_W(CNT_W)
    ) u_gen (
        .clk          (clk),
        .reset        (reset),
        .kill         (abort),
        .drain        (state == S_DRAIN),
        .period       (period),
        .shadow_valid (shadow_valid),
        .shadow_duty  (shadow_duty),
        .shadow_rep   (shadow_rep),
        .consume      (consume),
        .finish       (finish),
        .underrun_set (underrun_set),
        .pwm_out      (pwm_out)
    );

endmodule

// File: tb/tb_pwm_av_seq.sv
// Directed self-checking bench for pwm_av_seq with a behavioural RAM on the master port.
module tb_pwm_av_seq;

    logic        clk;
    logic        reset;
    logic [1:0]  ctrl_address;
    logic        ctrl_write;
    logic [31:0] ctrl_writedata;
    logic        ctrl_read;
    logic [31:0] ctrl_readdata;
    logic [12:0] m_address;
    logic        m_chipselect;
    logic [31:0] m_readdata;
    logic        pwm_out;
`ifdef PWM_AV_SEQ_IRQ_EN
    logic        irq;
`endif

    logic [31:0] mem [0:8191];
    logic [31:0] ram_q;
    logic [31:0] rdv;
    int          n_vec;
    int          n_err;

    pwm_av_seq dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_address   (ctrl_address),
        .ctrl_write     (ctrl_write),
        .ctrl_writedata (ctrl_writedata),
        .ctrl_read      (ctrl_read),
        .ctrl_readdata  (ctrl_readdata),
        .m_address      (m_address),
        .m_chipselect   (m_chipselect),
        .m_readdata     (m_readdata),
        .pwm_out        (pwm_out)
`ifdef PWM_AV_SEQ_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (m_chipselect) ram_q <= mem[m_address];
    end
    assign m_readdata = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        ctrl_address   = a;
        ctrl_writedata = d;
        ctrl_write     = 1'b1;
        @(negedge clk);
        ctrl_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        ctrl_address = a;
        ctrl_read    = 1'b1;
        @(negedge clk);
        ctrl_read    = 1'b0;
        d            = ctrl_readdata;
    endtask

    // Expected waveform for the {duty 3 rep 2, duty 7 rep 1} table at PERIOD 10.
    function automatic logic exp_337(input int k);
        int p;
        int duty;
        p    = (k / 10) % 3;
        duty = (p < 2) ? 3 : 7;
        return ((k % 10) < duty);
    endfunction

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b1;
        ctrl_address   = 2'd0;
        ctrl_write     = 1'b0;
        ctrl_writedata = 32'd0;
        ctrl_read      = 1'b0;
        ram_q          = 32'd0;
        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
        mem[0]     = {16'd2, 16'd3};
        mem[1]     = {16'd1, 16'd7};
        mem[8]     = {16'd1, 16'd0};
        mem[9]     = {16'd1, 16'd12};
        mem[8191]  = {16'd1, 16'd2};

        tick(3);
        reset = 1'b0;
        chk("reset pwm_out", 32'(pwm_out), 32'd0);
        chk("reset m_chipselect", 32'(m_chipselect), 32'd0);
        chk("reset m_address", 32'(m_address), 32'd0);
        chk("reset ctrl_readdata", ctrl_readdata, 32'd0);
`ifdef PWM_AV_SEQ_IRQ_EN
        chk("reset irq", 32'(irq), 32'd0);
`endif
        rd(2'd0, rdv);
        chk("reset status", rdv, 32'd0);

        // A: one-shot two-entry table
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd2);
        wr(2'd3, 32'd10);
        rd(2'd2, rdv);
        chk("A length readback", rdv, 32'd2);
        rd(2'd3, rdv);
        chk("A period readback", rdv, 32'd10);
        wr(2'd0, 32'd1);
        chk("A fetch0 cs", 32'(m_chipselect), 32'd1);
        chk("A fetch0 addr", 32'(m_address), 32'd0);
        tick(3);
        chk("A fetch1 cs", 32'(m_chipselect), 32'd1);
        chk("A fetch1 addr", 32'(m_address), 32'd1);
        tick(1);
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("A pwm k=%0d", k), 32'(pwm_out), 32'(exp_337(k)));
            if (k < 29) tick(1);
        end
        rd(2'd0, rdv);
        chk("A status done", rdv, 32'h0001_0002);
        chk("A pwm after done", 32'(pwm_out), 32'd0);

        // B: looped table over nine periods, then aborted
        wr(2'd0, 32'd0);
        wr(2'd0, 32'd3);
        tick(4);
        for (int k = 0; k < 90; k++) begin
            chk($sformatf("B pwm k=%0d", k), 32'(pwm_out), 32'(exp_337(k)));
            if (k < 89) tick(1);
        end
        rd(2'd0, rdv);
        chk("B status index1", rdv, 32'h0001_0001);
        tick(19);
        rd(2'd0, rdv);
        chk("B status index0", rdv, 32'h0000_0001);
        wr(2'd0, 32'd0);
        chk("B abort pwm", 32'(pwm_out), 32'd0);
        rd(2'd0, rdv);
        chk("B abort status", rdv, 32'd0);

        // C: START write while busy dropped, abort mid second period
        wr(2'd0, 32'd1);
        wr(2'd1, 32'd5);
        rd(2'd1, rdv);
        chk("C start locked", rdv, 32'd0);
        tick(12);
        chk("C pwm before abort", 32'(pwm_out), 32'd1);
        wr(2'd0, 32'd0);
        chk("C abort pwm", 32'(pwm_out), 32'd0);
        chk("C abort cs", 32'(m_chipselect), 32'd0);
        rd(2'd0, rdv);
        chk("C abort status", rdv, 32'h0001_0000);
        tick(10);
        chk("C pwm stays low", 32'(pwm_out), 32'd0);

        // D: duty 0 then duty above PERIOD
        wr(2'd1, 32'd8);
        wr(2'd0, 32'd1);
        tick(4);
        for (int k = 0; k < 19; k++) begin
            chk($sformatf("D pwm k=%0d", k), 32'(pwm_out), (k >= 10) ? 32'd1 : 32'd0);
            tick(1);
        end
        chk("D drain forces low", 32'(pwm_out), 32'd0);
        rd(2'd0, rdv);
        chk("D status done", rdv, 32'h0001_0002);
        wr(2'd0, 32'd0);

        // E: address wrap at top of RAM, PERIOD 2 runs as 4
        wr(2'd1, 32'h0000_1FFF);
        wr(2'd3, 32'd2);
        wr(2'd0, 32'd1);
        chk("E fetch0 addr", 32'(m_address), 32'h1FFF);
        tick(3);
        chk("E fetch1 cs", 32'(m_chipselect), 32'd1);
        chk("E fetch1 addr wrap", 32'(m_address), 32'd0);
        tick(1);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("E pwm k=%0d", k), 32'(pwm_out),
                32'((k < 4) ? ((k % 4) < 2) : ((k % 4) < 3)));
            if (k < 11) tick(1);
        end
        rd(2'd0, rdv);
        chk("E status no underrun", rdv, 32'h0001_0002);
        rd(2'd3, rdv);
        chk("E period raw readback", rdv, 32'd2);
        wr(2'd0, 32'd0);

        // F: single-entry table, completion flag and interrupt
        wr(2'd1, 32'd9);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd5);
        tick(6);
`ifdef PWM_AV_SEQ_IRQ_EN
        chk("F irq before done", 32'(irq), 32'd0);
`endif
        tick(1);
`ifdef PWM_AV_SEQ_IRQ_EN
        chk("F irq with done", 32'(irq), 32'd1);
`endif
        rd(2'd0, rdv);
        chk("F status done", rdv, 32'h0000_0002);
        wr(2'd0, 32'd2);
`ifdef PWM_AV_SEQ_IRQ_EN
        chk("F irq cleared", 32'(irq), 32'd0);
`endif
        rd(2'd0, rdv);
        chk("F done cleared", rdv, 32'd0);

        // G: reset in the middle of a run
        wr(2'd0, 32'd1);
        tick(4);
        chk("G pwm running", 32'(pwm_out), 32'd1);
        rd(2'd0, rdv);
        chk("G status busy", rdv, 32'h0000_0001);
        reset = 1'b1;
        tick(1);
        chk("G reset pwm_out", 32'(pwm_out), 32'd0);
        chk("G reset cs", 32'(m_chipselect), 32'd0);
        chk("G reset addr", 32'(m_address), 32'd0);
        chk("G reset readdata", ctrl_readdata, 32'd0);
`ifdef PWM_AV_SEQ_IRQ_EN
        chk("G reset irq", 32'(irq), 32'd0);
`endif
        reset = 1'b0;
        rd(2'd1, rdv);
        chk("G start cleared", rdv, 32'd0);
        rd(2'd0, rdv);
        chk("G status cleared", rdv, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
